// File: rtl/hazard_fwd_unit_if.sv
// Signal bundle between the ID stage and the hazard/forwarding unit.
interface hazard_fwd_unit_if #(
  parameter int unsigned CNT_W = 16
);
  logic [4:0]       ID_rs1;
  logic [4:0]       ID_rs2;
  logic             ID_rs1_used;
  logic             ID_rs2_used;
  logic [4:0]       ID_waddr;
  logic             CU_rf_we;
  logic [1:0]       CU_wb_sel;
  logic [31:0]      EX_result;
  logic [31:0]      MEM_wdata;
  logic [31:0]      WB_wdata;
  logic             EX_br_taken;
  logic             rd1_op;
  logic             rd2_op;
  logic [31:0]      rd1_f;
  logic [31:0]      rd2_f;
  logic             stall_pc;
  logic             stall_ifid;
  logic             flush_ifid;
  logic             flush_idex;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    output ID_rs1, ID_rs2, ID_rs1_used, ID_rs2_used, ID_waddr, CU_rf_we, CU_wb_sel,
    output EX_result, MEM_wdata, WB_wdata, EX_br_taken,
    input  rd1_op, rd2_op, rd1_f, rd2_f, stall_pc, stall_ifid, flush_ifid, flush_idex,
    input  stall_cnt, flush_cnt
  );

  modport slave (
    input  ID_rs1, ID_rs2, ID_rs1_used, ID_rs2_used, ID_waddr, CU_rf_we, CU_wb_sel,
    input  EX_result, MEM_wdata, WB_wdata, EX_br_taken,
    output rd1_op, rd2_op, rd1_f, rd2_f, stall_pc, stall_ifid, flush_ifid, flush_idex,
    output stall_cnt, flush_cnt
  );
endinterface

// File: rtl/hazard_fwd_unit.sv
// Hazard unit: shadows dest regs of EX/MEM/WB, forwards operands, inserts a
// single bubble on load-use and flushes on an EX redirect. Debug counters saturate.
module hazard_fwd_unit #(
  parameter logic [1:0]  WB_LOAD = 2'b01,
  parameter int unsigned CNT_W   = 16
) (
  input logic              clk,
  input logic              rst_n,  // active-high synchronous reset despite the name
  hazard_fwd_unit_if.slave hz
);

  typedef struct packed {
    logic       v;
    logic       we;
    logic [4:0] waddr;
    logic       ld;
  } slot_t;

  typedef struct packed {
    logic        lu;
    logic        op;
    logic [31:0] f;
  } fwd_t;

  slot_t            s_ex_q, s_mem_q, s_wb_q, s_ex_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;
  fwd_t             fwd1, fwd2;
  logic             lu, redirect, bubble;

  function automatic logic slot_match(slot_t s, logic [4:0] r);
    return s.v && s.we && (s.waddr == r) && (r != 5'd0);
  endfunction

  // An EX-stage load has no data yet: flag load-use instead of forwarding.
  function automatic fwd_t fwd_sel(logic used, logic [4:0] r, slot_t ex, slot_t mem, slot_t wb,
                                   logic [31:0] ex_v, logic [31:0] mem_v, logic [31:0] wb_v);
    fwd_t o;
    o = '0;
    if (used) begin
      if (slot_match(ex, r)) begin
        if (ex.ld) begin
          o.lu = 1'b1;
        end else begin
          o.op = 1'b1;
          o.f  = ex_v;
        end
      end else if (slot_match(mem, r)) begin
        o.op = 1'b1;
        o.f  = mem_v;
      end else if (slot_match(wb, r)) begin
        o.op = 1'b1;
        o.f  = wb_v;
      end
    end
    return o;
  endfunction

  // Per-operand forwarding and hazard detection.
  always_comb begin
    fwd1     = fwd_sel(hz.ID_rs1_used, hz.ID_rs1, s_ex_q, s_mem_q, s_wb_q,
                       hz.EX_result, hz.MEM_wdata, hz.WB_wdata);
    fwd2     = fwd_sel(hz.ID_rs2_used, hz.ID_rs2, s_ex_q, s_mem_q, s_wb_q,
                       hz.EX_result, hz.MEM_wdata, hz.WB_wdata);
    lu       = fwd1.lu | fwd2.lu;
    redirect = hz.EX_br_taken;
    bubble   = lu | redirect;
  end

  // Outputs, all forced low while in reset; redirect overrides the stall.
  always_comb begin
    hz.rd1_op     = 1'b0;
    hz.rd2_op     = 1'b0;
    hz.rd1_f      = '0;
    hz.rd2_f      = '0;
    hz.stall_pc   = 1'b0;
    hz.stall_ifid = 1'b0;
    hz.flush_ifid = 1'b0;
    hz.flush_idex = 1'b0;
    if (!rst_n) begin
      hz.rd1_op     = fwd1.op;
      hz.rd2_op     = fwd2.op;
      hz.rd1_f      = fwd1.f;
      hz.rd2_f      = fwd2.f;
      hz.stall_pc   = lu & ~redirect;
      hz.stall_ifid = lu & ~redirect;
      hz.flush_ifid = redirect;
      hz.flush_idex = bubble;
    end
  end

  assign hz.stall_cnt = stall_cnt_q;
  assign hz.flush_cnt = flush_cnt_q;

  // Next slot entering EX and saturating counter increments.
  always_comb begin
    s_ex_d = '0;
    if (!bubble) begin
      s_ex_d.v     = 1'b1;
      s_ex_d.we    = hz.CU_rf_we;
      s_ex_d.waddr = hz.ID_waddr;
      s_ex_d.ld    = (hz.CU_wb_sel == WB_LOAD);
    end
    stall_cnt_d = stall_cnt_q;
    if (lu && !redirect && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
    flush_cnt_d = flush_cnt_q;
    if (redirect && (flush_cnt_q != '1)) begin
      flush_cnt_d = flush_cnt_q + 1'b1;
    end
  end

  // Shadow pipe advance and counter state.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      s_ex_q      <= '0;
      s_mem_q     <= '0;
      s_wb_q      <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      s_ex_q      <= s_ex_d;
      s_mem_q     <= s_ex_q;
      s_wb_q      <= s_mem_q;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

endmodule

// File: tb/tb_hazard_fwd_unit.sv
// Directed bench for hazard_fwd_unit with a queue-based scoreboard.
module tb_hazard_fwd_unit;

  typedef struct packed {
    int          id;
    logic        op1;
    logic [31:0] f1;
    logic        op2;
    logic [31:0] f2;
    logic [3:0]  ctl;  // {stall_pc, stall_ifid, flush_ifid, flush_idex}
    logic [15:0] sc;
    logic [15:0] fc;
  } exp_t;

  logic clk;
  logic rst_n;
  logic [31:0] dx, dm, dw;
  exp_t sb[$];
  exp_t e_mon;
  int   n_chk;
  int   n_err;

  hazard_fwd_unit_if #(.CNT_W(16)) hz ();

  hazard_fwd_unit #(
    .WB_LOAD(2'b01),
    .CNT_W  (16)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .hz   (hz.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t mk(int id, logic o1, logic [31:0] f1, logic o2, logic [31:0] f2,
                              logic [3:0] ctl, logic [15:0] sc, logic [15:0] fc);
    exp_t e;
    e.id  = id;
    e.op1 = o1;
    e.f1  = f1;
    e.op2 = o2;
    e.f2  = f2;
    e.ctl = ctl;
    e.sc  = sc;
    e.fc  = fc;
    return e;
  endfunction

  task automatic chk(input string nm, input int id, input logic [31:0] act,
                     input logic [31:0] want);
    n_chk++;
    if (act !== want) begin
      n_err++;
      $display("FAIL vec%0d %s: got %h want %h", id, nm, act, want);
    end
  endtask

  // One cycle of stimulus applied just after the clock edge; optionally queue expectations.
  task automatic cyc(input logic rst, input logic [4:0] rs1, input logic [4:0] rs2,
                     input logic u1, input logic u2, input logic [4:0] wa, input logic we,
                     input logic [1:0] sel, input logic br, input logic do_chk, input exp_t e);
    @(posedge clk);
    #1;
    rst_n          = rst;
    hz.ID_rs1      = rs1;
    hz.ID_rs2      = rs2;
    hz.ID_rs1_used = u1;
    hz.ID_rs2_used = u2;
    hz.ID_waddr    = wa;
    hz.CU_rf_we    = we;
    hz.CU_wb_sel   = sel;
    hz.EX_br_taken = br;
    hz.EX_result   = dx;
    hz.MEM_wdata   = dm;
    hz.WB_wdata    = dw;
    if (do_chk) sb.push_back(e);
  endtask

  // Monitor: compare DUT outputs mid-cycle against the oldest queued expectation.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      e_mon = sb.pop_front();
      chk("rd1_op", e_mon.id, {31'd0, hz.rd1_op}, {31'd0, e_mon.op1});
      chk("rd1_f", e_mon.id, hz.rd1_f, e_mon.f1);
      chk("rd2_op", e_mon.id, {31'd0, hz.rd2_op}, {31'd0, e_mon.op2});
      chk("rd2_f", e_mon.id, hz.rd2_f, e_mon.f2);
      chk("ctl", e_mon.id,
          {28'd0, hz.stall_pc, hz.stall_ifid, hz.flush_ifid, hz.flush_idex},
          {28'd0, e_mon.ctl});
      chk("stall_cnt", e_mon.id, {16'd0, hz.stall_cnt}, {16'd0, e_mon.sc});
      chk("flush_cnt", e_mon.id, {16'd0, hz.flush_cnt}, {16'd0, e_mon.fc});
    end
  end

  initial begin
    n_chk          = 0;
    n_err          = 0;
    dx             = '0;
    dm             = '0;
    dw             = '0;
    rst_n          = 1'b1;
    hz.ID_rs1      = '0;
    hz.ID_rs2      = '0;
    hz.ID_rs1_used = 1'b0;
    hz.ID_rs2_used = 1'b0;
    hz.ID_waddr    = '0;
    hz.CU_rf_we    = 1'b0;
    hz.CU_wb_sel   = '0;
    hz.EX_br_taken = 1'b0;
    hz.EX_result   = '0;
    hz.MEM_wdata   = '0;
    hz.WB_wdata    = '0;
    repeat (2) @(posedge clk);

    // Reset state: outputs forced low even with a redirect present.
    cyc(1, 5'd5, 5'd1, 1, 1, 5'd0, 0, 2'b00, 1, 1, mk(0, 0, 0, 0, 0, 4'b0000, 0, 0));
    // add x5
    cyc(0, 5'd1, 5'd2, 1, 1, 5'd5, 1, 2'b00, 0, 1, mk(1, 0, 0, 0, 0, 4'b0000, 0, 0));
    // add x6,x5,x1: EX forward
    dx = 32'h0000_0011;
    cyc(0, 5'd5, 5'd1, 1, 1, 5'd6, 1, 2'b00, 0, 1,
        mk(2, 1, 32'h0000_0011, 0, 0, 4'b0000, 0, 0));
    // lw x7
    cyc(0, 5'd2, 5'd0, 1, 0, 5'd7, 1, 2'b01, 0, 1, mk(3, 0, 0, 0, 0, 4'b0000, 0, 0));
    // add x8,x7,x7: load-use bubble
    cyc(0, 5'd7, 5'd7, 1, 1, 5'd8, 1, 2'b00, 0, 1, mk(4, 0, 0, 0, 0, 4'b1101, 0, 0));
    // replayed add: MEM forward of load data
    dm = 32'hDEAD_BEEF;
    cyc(0, 5'd7, 5'd7, 1, 1, 5'd8, 1, 2'b00, 0, 1,
        mk(5, 1, 32'hDEAD_BEEF, 1, 32'hDEAD_BEEF, 4'b0000, 1, 0));
    // Three writers of x3
    for (int i = 0; i < 3; i++) begin
      cyc(0, 5'd0, 5'd0, 0, 0, 5'd3, 1, 2'b00, 0, 1, mk(6 + i, 0, 0, 0, 0, 4'b0000, 1, 0));
    end
    // Read x3 with x3 in EX/MEM/WB: youngest (EX) wins
    dx = 32'd1;
    dm = 32'd2;
    dw = 32'd3;
    cyc(0, 5'd3, 5'd3, 1, 0, 5'd3, 0, 2'b00, 0, 1, mk(9, 1, 32'd1, 0, 0, 4'b0000, 1, 0));
    // S_EX not writing: MEM wins
    cyc(0, 5'd3, 5'd3, 1, 1, 5'd3, 0, 2'b00, 0, 1, mk(10, 1, 32'd2, 1, 32'd2, 4'b0000, 1, 0));
    // EX and MEM not writing: WB forward; this instr loads into x0
    cyc(0, 5'd3, 5'd3, 1, 1, 5'd0, 1, 2'b01, 0, 1, mk(11, 1, 32'd3, 1, 32'd3, 4'b0000, 1, 0));
    // x0 loads filling the pipe, reads of x0: no forward, no stall
    cyc(0, 5'd0, 5'd0, 1, 1, 5'd0, 1, 2'b01, 0, 1, mk(12, 0, 0, 0, 0, 4'b0000, 1, 0));
    cyc(0, 5'd0, 5'd0, 1, 1, 5'd0, 1, 2'b01, 0, 1, mk(13, 0, 0, 0, 0, 4'b0000, 1, 0));
    // All slots x0; this instr is lw x4
    cyc(0, 5'd0, 5'd0, 1, 1, 5'd4, 1, 2'b01, 0, 1, mk(14, 0, 0, 0, 0, 4'b0000, 1, 0));
    // Load-use on x4 with redirect: flush only, stall_cnt unchanged
    cyc(0, 5'd4, 5'd0, 1, 0, 5'd9, 1, 2'b00, 1, 1, mk(15, 0, 0, 0, 0, 4'b0011, 1, 0));
    // x4 now in MEM; counters reflect the flush; this instr is lw x10
    dm = 32'h0000_0044;
    cyc(0, 5'd4, 5'd0, 1, 0, 5'd10, 1, 2'b01, 0, 1,
        mk(16, 1, 32'h0000_0044, 0, 0, 4'b0000, 1, 1));
    // Load-use on x10
    cyc(0, 5'd10, 5'd0, 1, 0, 5'd11, 1, 2'b01, 0, 1, mk(17, 0, 0, 0, 0, 4'b1101, 1, 1));
    // Replay: lw x11 reading x10 from MEM
    dm = 32'h0000_0055;
    cyc(0, 5'd10, 5'd0, 1, 0, 5'd11, 1, 2'b01, 0, 1,
        mk(18, 1, 32'h0000_0055, 0, 0, 4'b0000, 2, 1));
    // Reset during load-use on x11: outputs forced low, counters not yet cleared
    cyc(1, 5'd11, 5'd0, 1, 0, 5'd0, 0, 2'b00, 0, 1, mk(19, 0, 0, 0, 0, 4'b0000, 2, 1));
    // After reset: slots empty, no stall, counters zero
    cyc(0, 5'd11, 5'd0, 1, 0, 5'd0, 0, 2'b00, 0, 1, mk(20, 0, 0, 0, 0, 4'b0000, 0, 0));
    // Drive flush_cnt to all-ones
    for (int i = 0; i < 65535; i++) begin
      cyc(0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 2'b00, 1, 0, '0);
    end
    cyc(0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 2'b00, 1, 1, mk(21, 0, 0, 0, 0, 4'b0011, 0, 16'hFFFF));
    cyc(0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 2'b00, 0, 1, mk(22, 0, 0, 0, 0, 4'b0000, 0, 16'hFFFF));
    cyc(0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 2'b00, 0, 0, '0);
    repeat (2) @(posedge clk);

    n_chk++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain: got %0d pending want 0", sb.size());
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
